// File: rtl/csr_bank.sv
// Parametrised CSR bank: window decode, RW / RO-status / W1C-event registers,
// byte-enable writes, one-cycle registered response and aggregated interrupt.
module csr_bank #(
   parameter int          P_BASE_ADDR = 'hF00,
   parameter int          P_NUM_REGS  = 8,
   parameter int          P_AW        = 12,
   parameter int          P_DW        = 32,
   parameter logic [63:0] P_RO_MASK   = 64'h0,
   parameter logic [63:0] P_W1C_MASK  = 64'h0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       we,
   input  logic [P_AW-1:0]            addr,
   input  logic [P_DW-1:0]            wdata,
   input  logic [P_DW/8-1:0]          be,
   output logic                       ack,
   output logic                       err,
   output logic [P_DW-1:0]            rdata,
   output logic [P_NUM_REGS*P_DW-1:0] csr,
   input  logic [P_NUM_REGS*P_DW-1:0] hw_status,
   input  logic [P_NUM_REGS*P_DW-1:0] hw_set,
   output logic                       irq
);

   localparam int IW = $clog2(P_NUM_REGS);
   localparam int NB = P_DW / 8;
   localparam logic [P_AW:0] WIN_LO = (P_AW+1)'(P_BASE_ADDR);
   localparam logic [P_AW:0] WIN_HI = (P_AW+1)'(P_BASE_ADDR + 4 * P_NUM_REGS);

   logic [P_DW-1:0] reg_q [P_NUM_REGS];
   logic [P_DW-1:0] reg_d [P_NUM_REGS];
   logic            ack_q, err_q;
   logic [P_DW-1:0] rdata_q;

   logic            hit, mis, wr_ok, ro_tgt;
   logic [IW-1:0]   idx;
   logic [P_DW-1:0] bmask;

   // Request decode: the window is compared one bit wider so the top edge cannot wrap.
   always_comb begin
      hit    = en && ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
      mis    = (addr[1:0] != 2'b00);
      idx    = addr[IW+1:2];
      wr_ok  = hit && we && !mis;
      ro_tgt = P_RO_MASK[idx];
      bmask  = '0;
      for (int k = 0; k < NB; k++) begin
         bmask[k*8 +: 8] = {8{be[k]}};
      end
   end

   always_comb begin
      logic            wsel;
      logic [P_DW-1:0] clr;
      wsel = 1'b0;
      clr  = '0;
      for (int i = 0; i < P_NUM_REGS; i++) begin
         wsel = wr_ok && (idx == IW'(i));
         clr  = wsel ? (wdata & bmask) : '0;
         if (P_RO_MASK[i]) begin
            reg_d[i] = hw_status[i*P_DW +: P_DW];
         end else if (P_W1C_MASK[i]) begin
            // Set is OR-ed after the clear so a simultaneous hw event is never lost.
            reg_d[i] = (reg_q[i] & ~clr) | hw_set[i*P_DW +: P_DW];
         end else if (wsel) begin
            reg_d[i] = (reg_q[i] & ~bmask) | (wdata & bmask);
         end else begin
            reg_d[i] = reg_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         for (int i = 0; i < P_NUM_REGS; i++) begin
            reg_q[i] <= '0;
         end
      end else begin
         ack_q <= hit;
         err_q <= hit && (mis || (we && ro_tgt));
         if (hit && !we && !mis) begin
            rdata_q <= reg_q[idx];
         end
         for (int i = 0; i < P_NUM_REGS; i++) begin
            reg_q[i] <= reg_d[i];
         end
      end
   end

   always_comb begin
      irq = 1'b0;
      for (int i = 0; i < P_NUM_REGS; i++) begin
         if (P_W1C_MASK[i]) begin
            irq = irq | (|reg_q[i]);
         end
      end
   end

   for (genvar g = 0; g < P_NUM_REGS; g++) begin : g_csr
      assign csr[g*P_DW +: P_DW] = reg_q[g];
   end

   assign ack   = ack_q;
   assign err   = err_q;
   assign rdata = rdata_q;

   // Status/set slices of registers of the other kinds are intentionally ignored.
   logic unused_in;
   assign unused_in = ^{hw_status, hw_set};

endmodule

// File: tb/tb_csr_bank.sv
// Randomised scoreboard bench for csr_bank with reg1 read-only and reg2 W1C.
module tb_csr_bank;

   localparam int          NR    = 8;
   localparam logic [7:0]  RO_M  = 8'h02;
   localparam logic [7:0]  W1C_M = 8'h04;

   logic         clk = 1'b0;
   logic         rst, en, we;
   logic [11:0]  addr;
   logic [31:0]  wdata;
   logic [3:0]   be;
   logic         ack, err, irq;
   logic [31:0]  rdata;
   logic [255:0] csr, hw_status, hw_set;

   logic [31:0] hs [NR];
   logic [31:0] hset [NR];
   logic [31:0] p_hs [NR];
   logic [31:0] p_hset [NR];

   logic [31:0] m_reg [NR];
   logic [31:0] m_rdata;
   logic        exp_q [$];
   bit          mon_on = 1'b0;
   int          n_chk = 0;
   int          n_pass = 0;

   csr_bank #(
      .P_BASE_ADDR('hF00), .P_NUM_REGS(8), .P_AW(12), .P_DW(32),
      .P_RO_MASK(64'h02), .P_W1C_MASK(64'h04)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .wdata(wdata), .be(be),
      .ack(ack), .err(err), .rdata(rdata), .csr(csr),
      .hw_status(hw_status), .hw_set(hw_set), .irq(irq)
   );

   for (genvar g = 0; g < NR; g++) begin : g_pack
      assign hw_status[g*32 +: 32] = hs[g];
      assign hw_set[g*32 +: 32]    = hset[g];
   end

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %h, want %h at %0t", nm, act, exp_v, $time);
   endtask

   // Reference: applies the register rules to the current inputs for one clock edge.
   task automatic model_step();
      int          a, idx;
      bit          hit, mis, wr;
      logic [31:0] mask, clear;
      if (rst) begin
         for (int i = 0; i < NR; i++) m_reg[i] = 32'h0;
         m_rdata = 32'h0;
         return;
      end
      a    = int'(addr);
      hit  = en && (a >= 'hF00) && (a < 'hF00 + 4 * NR);
      idx  = (a - 'hF00) / 4;
      mis  = (a % 4) != 0;
      wr   = hit && we && !mis;
      mask = 32'h0;
      for (int k = 0; k < 4; k++) if (be[k]) mask = mask | (32'hFF << (8 * k));
      if (hit) begin
         exp_q.push_back(mis || (we && RO_M[idx]));
         if (!we && !mis) m_rdata = m_reg[idx];
      end
      for (int i = 0; i < NR; i++) begin
         if (RO_M[i]) m_reg[i] = hs[i];
         else if (W1C_M[i]) begin
            clear    = (wr && idx == i) ? (wdata & mask) : 32'h0;
            m_reg[i] = (m_reg[i] & ~clear) | hset[i];
         end else if (wr && idx == i) m_reg[i] = (m_reg[i] & ~mask) | (wdata & mask);
      end
   endtask

   task automatic cycle(input bit r, input bit e, input bit w, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      #1;
      rst = r; en = e; we = w; addr = a; wdata = d; be = b;
      for (int i = 0; i < NR; i++) begin
         hs[i]   = p_hs[i];
         hset[i] = p_hset[i];
      end
      model_step();
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
   endtask

   always @(negedge clk) begin
      bit   exp_ack;
      logic e_err;
      logic m_irq;
      if (mon_on) begin
         exp_ack = (exp_q.size() != 0);
         chk("ack", 32'(ack), 32'(exp_ack));
         if (exp_ack) begin
            e_err = exp_q.pop_front();
            if (ack) chk("err", 32'(err), 32'(e_err));
         end
         chk("rdata", rdata, m_rdata);
         m_irq = 1'b0;
         for (int i = 0; i < NR; i++) begin
            chk($sformatf("csr%0d", i), csr[i*32 +: 32], m_reg[i]);
            if (W1C_M[i]) m_irq = m_irq | (m_reg[i] != 0);
         end
         chk("irq", 32'(irq), 32'(m_irq));
      end
   end

   initial begin
      for (int i = 0; i < NR; i++) begin
         p_hs[i]   = 32'h0;
         p_hset[i] = 32'h0;
      end
      cycle(1'b1, 1'b1, 1'b0, 12'hF00, 32'h0, 4'hF);
      mon_on = 1'b1;
      cycle(1'b1, 1'b1, 1'b1, 12'hF0C, 32'hFFFFFFFF, 4'hF);
      idle();
      chk("reset_ack", 32'(ack), 32'h0);
      chk("reset_csr3", csr[127:96], 32'h0);

      cycle(1'b0, 1'b1, 1'b1, 12'hF0C, 32'hDEADBEEF, 4'hF);
      cycle(1'b0, 1'b1, 1'b1, 12'hF0C, 32'h00000011, 4'h1);
      cycle(1'b0, 1'b1, 1'b0, 12'hF0C, 32'h0, 4'h0);
      idle();
      chk("rw_rdata", rdata, 32'hDEADBE11);
      chk("rw_csr3", csr[127:96], 32'hDEADBE11);

      cycle(1'b0, 1'b1, 1'b0, 12'hEFC, 32'h0, 4'h0);
      cycle(1'b0, 1'b1, 1'b0, 12'hF20, 32'h0, 4'h0);
      idle(); idle(); idle();
      cycle(1'b0, 1'b1, 1'b0, 12'hF05, 32'h0, 4'h0);
      idle();
      chk("mis_ackerr", {30'h0, ack, err}, 32'h3);
      chk("mis_rdata", rdata, 32'hDEADBE11);

      p_hs[1] = 32'h1234;
      idle();
      cycle(1'b0, 1'b1, 1'b0, 12'hF04, 32'h0, 4'h0);
      idle();
      chk("ro_rdata", rdata, 32'h1234);
      cycle(1'b0, 1'b1, 1'b1, 12'hF04, 32'hFFFF, 4'hF);
      idle();
      chk("ro_werr", {30'h0, ack, err}, 32'h3);
      chk("ro_csr1", csr[63:32], 32'h1234);

      p_hset[2] = 32'h21;
      idle();
      p_hset[2] = 32'h0;
      idle();
      chk("w1c_set", csr[95:64], 32'h21);
      chk("w1c_irq1", 32'(irq), 32'h1);
      cycle(1'b0, 1'b1, 1'b1, 12'hF08, 32'h01, 4'hF);
      idle();
      chk("w1c_clr0", csr[95:64], 32'h20);
      p_hset[2] = 32'h20;
      cycle(1'b0, 1'b1, 1'b1, 12'hF08, 32'h20, 4'hF);
      p_hset[2] = 32'h0;
      idle();
      chk("w1c_setwins", csr[95:64], 32'h20);
      cycle(1'b0, 1'b1, 1'b1, 12'hF08, 32'h20, 4'hF);
      idle();
      chk("w1c_clr5", csr[95:64], 32'h0);
      chk("w1c_irq0", 32'(irq), 32'h0);

      for (int i = 0; i < NR; i++) cycle(1'b0, 1'b1, 1'b1, 12'hF00 + 12'(4 * i), $urandom, 4'hF);
      for (int i = 0; i < NR; i++) cycle(1'b0, 1'b1, 1'b0, 12'hF00 + 12'(4 * i), 32'h0, 4'h0);
      idle();

      for (int n = 0; n < 3000; n++) begin
         logic [11:0] a;
         for (int i = 0; i < NR; i++) begin
            p_hs[i]   = $urandom;
            p_hset[i] = ($urandom_range(7) == 0) ? (32'h1 << $urandom_range(31)) : 32'h0;
         end
         a = ($urandom_range(9) < 8) ? 12'(12'hF00 + $urandom_range(31)) : 12'($urandom);
         cycle($urandom_range(63) == 0, $urandom_range(3) != 0, 1'($urandom),
               a, $urandom, 4'($urandom));
      end
      for (int i = 0; i < NR; i++) p_hset[i] = 32'h0;
      idle(); idle();
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/csr_bank.md
# csr_bank

Parametrised control/status register bank on the shared CSR bus, the successor to the fixed 8×32 register slice. Decodes a base-address window, provides per-register access modes (read-write, read-only hardware status, write-1-to-clear event flags), byte-enable writes, a registered one-cycle response with error reporting, and an aggregated interrupt. All RW/W1C register contents go out on a flat vector to the datapath.

## Interface
Parameters:
- P_BASE_ADDR, 'hF00, byte address of register 0; must be aligned to P_NUM_REGS*4
- P_NUM_REGS, 8, register count; power of two, 2..64
- P_AW, 12, bus address width
- P_DW, 32, register/data width; multiple of 8
- P_RO_MASK, 0, bit i=1: register i is read-only, loaded from hw_status
- P_W1C_MASK, 0, bit i=1: register i is W1C event flags, set from hw_set; must not overlap P_RO_MASK

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  request valid this cycle
- we  in  1  1 = write, 0 = read
- addr  in  P_AW  byte address
- wdata  in  P_DW  write data
- be  in  P_DW/8  byte enables for writes
- ack  out  1  response pulse, cycle after an in-window request
- err  out  1  error qualifier, valid with ack
- rdata  out  P_DW  read data, valid with ack on reads, held otherwise
- csr  out  P_NUM_REGS*P_DW  register contents, register i at [i*P_DW +: P_DW]
- hw_status  in  P_NUM_REGS*P_DW  values sampled into RO registers
- hw_set  in  P_NUM_REGS*P_DW  per-bit set pulses for W1C registers
- irq  out  1  OR of all bits of all W1C registers

## Operation
- Hit: en=1 and P_BASE_ADDR <= addr < P_BASE_ADDR + 4*P_NUM_REGS. Index = addr[log2(P_NUM_REGS)+1:2]. Non-hits: no state change, no ack. Other slaves share the bus.
- Misaligned hit (addr[1:0]≠0): ack=1, err=1. No register change, rdata unchanged.
- RW write: bytes with be[k]=1 take wdata. Other bytes hold. be=0: ack, no change, err=0.
- RO register:
  - Loads hw_status slice every cycle.
  - Bus write is ignored: ack=1, err=1.
  - Read returns the current (pre-edge) value.
- W1C register, per bit, next value = (cur & ~clr) | set:
  - set = hw_set bit.
  - clr = bus write to this register with that wdata bit = 1 in an enabled byte.
  - Simultaneous set and clear: set wins, bit stays 1.
- Read hit, aligned: rdata <= register value before the edge, ack=1, err=0. Same-cycle hw_set/hw_status updates are not visible until the next read.
- csr and irq reflect register state (registered, no combinational path from bus inputs).
- No back-pressure. One request per cycle is accepted every cycle.
- Reset (rst=1 at edge): all registers, rdata, ack, err, irq <= 0. hw_set and requests are ignored that cycle. Reset mid-stream drops any pending response: ack=0 the following cycle.

## Timing
- Request in cycle N: ack/err/rdata valid in cycle N+1; register update visible on csr in N+1.
- ack is a single-cycle pulse per hit. Back-to-back hits give ack high on consecutive cycles.
- Read-after-write to the same register on consecutive cycles returns the written data.
- hw_set in cycle N: bit visible on csr and irq in N+1. Clearing write in N: irq low in N+1 if no other W1C bit set.
- RO register: hw_status in N appears on csr in N+1; a read issued in N+1 returns it in N+2.

## Test plan
- Reset: assert rst 2 cycles with en=1 → csr=0, rdata=0, ack=0, err=0, irq=0.
- RW byte write: default params, write reg 3 = 'hDEADBEEF be='hF, then 'h00000011 be='h1; read reg 3 → ack=1, err=0, rdata='hDEADBE11; csr[127:96]='hDEADBE11.
- Decode:
  - Read addr 'hEFC or 'hF20 → no ack for 3 cycles.
  - Read 'hF05 → ack=1, err=1, rdata unchanged.
- RO: P_RO_MASK='h02, hw_status reg1='h1234 → read 'hF04 returns 'h1234. Write 'hF04='hFFFF → ack=1, err=1, value still 'h1234.
- W1C/irq: P_W1C_MASK='h04.
  - Pulse hw_set bit0 and bit5 of reg2 → csr reg2='h21, irq=1.
  - Write 'hF08='h01 → 'h20, irq=1.
  - Write 'h20 in the same cycle as hw_set bit5 → stays 'h20.
  - Write 'h20 alone → 0, irq=0 next cycle.
- Throughput: 8 back-to-back writes then 8 back-to-back reads, P_NUM_REGS=8 → 16 consecutive ack pulses, each read returns its written value.
